dp_mem_arbiter: RTL and testbench
=================================

Name: dp_mem_arbiter

Overview:
- Two-requester access arbiter sitting in front of dp_mem; owns dp_mem's enb/wr/rd/w_addr/r_addr/w_data ports and returns r_data to requesters.
- Independent round-robin arbitration on the write channel and the read channel.
- Registered memory command issue, read-data return with valid strobe, same-address read/write collision stall.

Parameters:
- ADDR_W, 4, address width (matches dp_mem w_addr/r_addr)
- DATA_W, 8, data width (matches dp_mem w_data/r_data)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- wreq0, wreq1  in  1  write request
- waddr0, waddr1  in  ADDR_W  write address, held while wreq high
- wdata0, wdata1  in  DATA_W  write data, held while wreq high
- wgnt0, wgnt1  out  1  write grant (combinational)
- rreq0, rreq1  in  1  read request
- raddr0, raddr1  in  ADDR_W  read address, held while rreq high
- rgnt0, rgnt1  out  1  read grant (combinational)
- rvalid0, rvalid1  out  1  read data valid, one-cycle pulse
- rdata0, rdata1  out  DATA_W  read data, meaningful only with rvalid
- mem_enb  out  1  to dp_mem enb
- mem_wr  out  1  to dp_mem wr
- mem_rd  out  1  to dp_mem rd
- mem_w_addr  out  ADDR_W  to dp_mem w_addr
- mem_r_addr  out  ADDR_W  to dp_mem r_addr
- mem_w_data  out  DATA_W  to dp_mem w_data
- mem_r_data  in  DATA_W  from dp_mem r_data

Behaviour:
- Reset (rst low, async): mem_* outputs 0, rvalid* 0, rdata* 0, both priority pointers to requester 0, read-return pipeline cleared. Grants are 0 while rst low.
- Transfer rule: a request is accepted at the rising edge where req & gnt are both 1. The requester holds req/addr/data until it sees gnt; deasserting req without a grant is legal (request withdrawn).
- Write arbitration, cycle N:
  - One wreq: granted.
  - Both: grant the requester named by wptr.
  - On acceptance, wptr moves to the other requester. With no grant, wptr holds.
- Read arbitration: identical scheme with its own pointer rptr.
- Issue latency: an accepted write at edge N drives mem_wr=1 with addr/data during cycle N+1. An accepted read at edge N drives mem_rd=1 and mem_r_addr during N+1.
- mem_enb = mem_wr | mem_rd, registered. Idle cycles drive mem_wr/mem_rd/mem_enb to 0; address/data hold their last values.
- Read return:
  - dp_mem presents r_data in the cycle after mem_rd.
  - The arbiter registers requester ID through a 2-stage pipeline.
  - rvalid_k pulses in cycle N+2 for a read accepted at edge N; rdata_k = mem_r_data combinationally in that cycle.
  - The non-target rvalid stays 0.
- Collision: if a read and a write would both be granted in cycle N with raddr == waddr of the write winner, the write is granted and the read is withheld (no rgnt that cycle, rptr unchanged). The read is re-evaluated in N+1 and returns post-write data.
- Back-to-back: one write and one read accepted every cycle is sustainable. rvalid can pulse every cycle.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset release. The first grant after release follows pointer = 0.

Test Plan:
- Reset then idle: all mem_* 0, rvalid0/1 0, gnts 0 with no reqs; rst low mid-read at N+1 -> no rvalid at N+2.
- Single write then read: req0 writes addr 3 data 8'hA5 at N -> mem_wr=1, mem_w_addr=3, mem_w_data=A5 at N+1. req0 reads addr 3 at N+3 -> rvalid0=1, rdata0=A5 at N+5; rvalid1 stays 0.
- Contention round-robin: both wreq held for 4 cycles from reset -> grants 0,1,0,1; mem_w_data alternates wdata0/wdata1. Same check for reads, with rvalid alternating.
- Collision: wreq0 addr 5 data 8'h3C and rreq1 addr 5 in the same cycle -> wgnt0=1, rgnt1=0 in that cycle, rgnt1=1 next cycle, rvalid1 returns 8'h3C.
- Non-colliding concurrency: write addr 2 and read addr 7 in the same cycle -> both granted, mem_wr=mem_rd=mem_enb=1 in the same cycle.
- Withdrawn request: rreq1 loses to rreq0, then drops -> no rgnt1, no rvalid1, rptr points to 1 after rreq0 is served.

Source files
------------

// File: rtl/dp_mem_arbiter.sv
// Purpose: two-requester round-robin arbiter owning the dp_mem write and read ports.
// Latency: accepted command reaches mem_* one cycle later; read data returns two cycles after acceptance.
// Backpressure: grants are combinational; a requester holds req/addr/data until it sees its grant.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   wreq*/waddr*/wdata* write requests from requester 0/1, wgnt* combinational grants
//   rreq*/raddr*        read requests from requester 0/1, rgnt* combinational grants
//   rvalid*/rdata*      one-cycle read return strobe and data per requester
//   mem_*               command/data interface to dp_mem (registered), mem_r_data from dp_mem
module dp_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wreq0,
  input  logic              wreq1,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              wgnt0,
  output logic              wgnt1,
  input  logic              rreq0,
  input  logic              rreq1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic              rgnt0,
  output logic              rgnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_enb,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  // Priority pointers: 0 favours requester 0 on a tie, 1 favours requester 1.
  logic wptr;
  logic rptr;

  logic              w_any;
  logic              r_any;
  logic              r_cand0;
  logic              r_cand1;
  logic              collide;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [ADDR_W-1:0] r_cand_addr;

  // Read-return pipeline: stage 1 aligns with mem_rd, stage 2 with dp_mem r_data.
  logic rd_s1_vld;
  logic rd_s1_id;
  logic rd_s2_vld;
  logic rd_s2_id;

  // Write arbitration; grants are forced low while reset is asserted.
  assign wgnt0      = rst & wreq0 & (~wreq1 | ~wptr);
  assign wgnt1      = rst & wreq1 & (~wreq0 |  wptr);
  assign w_any      = wgnt0 | wgnt1;
  assign w_win_addr = wgnt1 ? waddr1 : waddr0;
  assign w_win_data = wgnt1 ? wdata1 : wdata0;

  // Read arbitration picks a candidate first; the candidate is then withheld
  // if it targets the same address as this cycle's write winner, so the read
  // is retried next cycle and observes the freshly written data.
  assign r_cand0     = rst & rreq0 & (~rreq1 | ~rptr);
  assign r_cand1     = rst & rreq1 & (~rreq0 |  rptr);
  assign r_cand_addr = r_cand1 ? raddr1 : raddr0;
  assign collide     = w_any & (r_cand0 | r_cand1) & (r_cand_addr == w_win_addr);
  assign rgnt0       = r_cand0 & ~collide;
  assign rgnt1       = r_cand1 & ~collide;
  assign r_any       = rgnt0 | rgnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      mem_enb    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_w_addr <= '0;
      mem_r_addr <= '0;
      mem_w_data <= '0;
      rd_s1_vld  <= 1'b0;
      rd_s1_id   <= 1'b0;
      rd_s2_vld  <= 1'b0;
      rd_s2_id   <= 1'b0;
    end else begin
      mem_wr  <= w_any;
      mem_rd  <= r_any;
      mem_enb <= w_any | r_any;
      // Pointer moves to the other requester only when a grant is taken.
      if (w_any) begin
        mem_w_addr <= w_win_addr;
        mem_w_data <= w_win_data;
        wptr       <= wgnt0;
      end
      if (r_any) begin
        mem_r_addr <= r_cand_addr;
        rptr       <= rgnt0;
      end
      rd_s1_vld <= r_any;
      rd_s1_id  <= rgnt1;
      rd_s2_vld <= rd_s1_vld;
      rd_s2_id  <= rd_s1_id;
    end
  end

  assign rvalid0 = rd_s2_vld & ~rd_s2_id;
  assign rvalid1 = rd_s2_vld &  rd_s2_id;
  assign rdata0  = rvalid0 ? mem_r_data : '0;
  assign rdata1  = rvalid1 ? mem_r_data : '0;

endmodule

// File: tb/tb_dp_mem_arbiter.sv
// Purpose: directed scoreboard bench for dp_mem_arbiter with a behavioural dp_mem.
// Latency: expectations carry the cycle in which each mem command / rvalid must appear.
// Backpressure: stimulus drives fixed per-cycle request patterns with hand-computed grants.
module tb_dp_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       wreq0, wreq1, rreq0, rreq1;
  logic [3:0] waddr0, waddr1, raddr0, raddr1;
  logic [7:0] wdata0, wdata1;
  logic       wgnt0, wgnt1, rgnt0, rgnt1;
  logic       rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_enb, mem_wr, mem_rd;
  logic [3:0] mem_w_addr, mem_r_addr;
  logic [7:0] mem_w_data;
  logic [7:0] mem_r_data;

  logic [7:0] rexp0, rexp1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t v0q[$];
  exp_t v1q[$];
  exp_t me;

  logic [7:0] mem [16];

  dp_mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst_n),
    .wreq0(wreq0), .wreq1(wreq1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .wgnt0(wgnt0), .wgnt1(wgnt1),
    .rreq0(rreq0), .rreq1(rreq1), .raddr0(raddr0), .raddr1(raddr1),
    .rgnt0(rgnt0), .rgnt1(rgnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_enb(mem_enb), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dp_mem: synchronous write, registered read (data the cycle after rd).
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem_r_data = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_enb && mem_wr) mem[mem_w_addr] <= mem_w_data;
    if (mem_enb && mem_rd) mem_r_data <= mem[mem_r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a command or a read return.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_wr) begin
        if (wq.size() == 0) chk("unexpected mem_wr", {31'd0, mem_wr}, 32'd0);
        else begin
          me = wq.pop_front();
          chk("mem_wr cycle", cyc, me.c);
          chk("mem_w_addr", {28'd0, mem_w_addr}, {28'd0, me.a});
          chk("mem_w_data", {24'd0, mem_w_data}, {24'd0, me.d});
        end
      end
      if (mem_rd) begin
        if (rq.size() == 0) chk("unexpected mem_rd", {31'd0, mem_rd}, 32'd0);
        else begin
          me = rq.pop_front();
          chk("mem_rd cycle", cyc, me.c);
          chk("mem_r_addr", {28'd0, mem_r_addr}, {28'd0, me.a});
        end
      end
      if (mem_enb || mem_wr || mem_rd)
        chk("mem_enb", {31'd0, mem_enb}, {31'd0, mem_wr | mem_rd});
      if (rvalid0) begin
        if (v0q.size() == 0) chk("unexpected rvalid0", {31'd0, rvalid0}, 32'd0);
        else begin
          me = v0q.pop_front();
          chk("rvalid0 cycle", cyc, me.c);
          chk("rdata0", {24'd0, rdata0}, {24'd0, me.d});
        end
      end
      if (rvalid1) begin
        if (v1q.size() == 0) chk("unexpected rvalid1", {31'd0, rvalid1}, 32'd0);
        else begin
          me = v1q.pop_front();
          chk("rvalid1 cycle", cyc, me.c);
          chk("rdata1", {24'd0, rdata1}, {24'd0, me.d});
        end
      end
    end
  end

  // One cycle of stimulus; eg = expected {wgnt0,wgnt1,rgnt0,rgnt1}.
  task automatic drive(input logic w0, input logic w1, input logic r0, input logic r1,
                       input logic [3:0] eg, input string nm);
    wreq0 = w0; wreq1 = w1; rreq0 = r0; rreq1 = r1;
    @(negedge clk);
    chk({nm, " grants"}, {28'd0, wgnt0, wgnt1, rgnt0, rgnt1}, {28'd0, eg});
    if (eg[3]) wq.push_back('{cyc + 1, waddr0, wdata0});
    if (eg[2]) wq.push_back('{cyc + 1, waddr1, wdata1});
    if (eg[1]) begin
      rq.push_back('{cyc + 1, raddr0, 8'h00});
      v0q.push_back('{cyc + 2, 4'h0, rexp0});
    end
    if (eg[0]) begin
      rq.push_back('{cyc + 1, raddr1, 8'h00});
      v1q.push_back('{cyc + 2, 4'h0, rexp1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "idle");
  endtask

  // Hold reset one cycle with all requests raised; outputs and grants must be 0.
  task automatic reset_phase(input string nm);
    wreq0 = 1'b1; wreq1 = 1'b1; rreq0 = 1'b1; rreq1 = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk({nm, " gnt in reset"}, {28'd0, wgnt0, wgnt1, rgnt0, rgnt1}, 32'd0);
    chk({nm, " mem ctl"}, {29'd0, mem_enb, mem_wr, mem_rd}, 32'd0);
    chk({nm, " mem addr"}, {24'd0, mem_w_addr, mem_r_addr}, 32'd0);
    chk({nm, " mem wdata"}, {24'd0, mem_w_data}, 32'd0);
    chk({nm, " rvalid"}, {30'd0, rvalid0, rvalid1}, 32'd0);
    chk({nm, " rdata"}, {16'd0, rdata0, rdata1}, 32'd0);
    @(posedge clk);
    #1;
    wreq0 = 1'b0; wreq1 = 1'b0; rreq0 = 1'b0; rreq1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    wreq0 = 1'b0; wreq1 = 1'b0; rreq0 = 1'b0; rreq1 = 1'b0;
    waddr0 = 4'h0; waddr1 = 4'h0; raddr0 = 4'h0; raddr1 = 4'h0;
    wdata0 = 8'h00; wdata1 = 8'h00; rexp0 = 8'h00; rexp1 = 8'h00;
    rst_n = 1'b0;

    reset_phase("por");
    idle(2);

    // Single write then read by requester 0 three cycles later.
    waddr0 = 4'd3; wdata0 = 8'hA5;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, "single wr");
    idle(2);
    raddr0 = 4'd3; rexp0 = 8'hA5;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, "single rd");
    idle(3);

    // Contention from reset: writes then reads alternate 0,1,0,1.
    reset_phase("rst2");
    waddr0 = 4'd0; wdata0 = 8'h11; waddr1 = 4'd1; wdata1 = 8'h22;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, "wr rr 1");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, "wr rr 2");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, "wr rr 3");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, "wr rr 4");
    raddr0 = 4'd0; rexp0 = 8'h11; raddr1 = 4'd1; rexp1 = 8'h22;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, "rd rr 1");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, "rd rr 2");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, "rd rr 3");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, "rd rr 4");
    idle(3);

    // Non-colliding write and read in the same cycle.
    waddr1 = 4'd7; wdata1 = 8'h77;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, "wr7");
    waddr0 = 4'd2; wdata0 = 8'h5A; raddr1 = 4'd7; rexp1 = 8'h77;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, "concurrent");
    idle(3);

    // Same-address collision: read stalls one cycle and returns the new data.
    waddr0 = 4'd5; wdata0 = 8'h3C; raddr1 = 4'd5; rexp1 = 8'h3C;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, "collide");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, "collide retry");
    idle(3);

    // Withdrawn request: rreq1 loses, drops, and rptr then favours requester 1.
    raddr0 = 4'd0; rexp0 = 8'h11; raddr1 = 4'd1; rexp1 = 8'h22;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, "withdraw lose");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "withdraw drop");
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, "rptr after");
    idle(3);

    // Reset during an in-flight read: its rvalid must never appear.
    raddr0 = 4'd0; rexp0 = 8'h11;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, "midrd");
    rst_n = 1'b0;
    void'(rq.pop_back());
    void'(v0q.pop_back());
    reset_phase("midrd rst");
    idle(4);

    // First grants after release follow pointer 0 on both channels.
    waddr0 = 4'd9; wdata0 = 8'h99; waddr1 = 4'd10; wdata1 = 8'hAA;
    raddr0 = 4'd0; rexp0 = 8'h11; raddr1 = 4'd1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, "post rst ptr");
    idle(4);

    chk("wq drained", wq.size(), 32'd0);
    chk("rq drained", rq.size(), 32'd0);
    chk("v0q drained", v0q.size(), 32'd0);
    chk("v1q drained", v1q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
